// File: rtl/up_counter_pkg.sv
// Shared constants for the up counter slice.
// Holds the default counter width used by the interface and the counter.
package up_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/up_counter_if.sv
// Bundle of the counter control and result signals.
// The master drives reset/enable and observes the count.
interface up_counter_if
    import up_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             reset;
    logic             en;
    logic [WIDTH-1:0] count;

    modport master (
        output reset,
        output en,
        input  count
    );

    modport slave (
        input  reset,
        input  en,
        output count
    );

endinterface

// File: rtl/up_counter.sv
// Free-running up counter with synchronous reset and count enable.
// Ports stay scalar and in fixed order so positional instances still bind.
module up_counter
    import up_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             reset,
    input  logic             clk,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Reset wins over enable; the add wraps naturally at 2^WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_up_counter.sv
// Directed self-checking bench for up_counter (WIDTH=8).
// Stimulus changes on the falling edge; results sampled 1 unit after rising.
`timescale 1ns/1ps
module tb_up_counter;

    localparam int W = 8;

    logic clk;
    int   n_cmp;
    int   n_bad;

    up_counter_if #(.WIDTH(W)) bus ();

    up_counter #(.WIDTH(W)) dut (
        .reset (bus.reset),
        .clk   (clk),
        .en    (bus.en),
        .count (bus.count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e);
        @(negedge clk);
        bus.reset = r;
        bus.en    = e;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0);
        tick();
        n_cmp++;
        if (bus.count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset: count=%0d expected=0", bus.count);
        end
    endtask

    task automatic test_count_hold();
        drive(1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (bus.count !== 8'(i)) begin
                n_bad++;
                $display("FAIL count_%0d: count=%0d expected=%0d",
                         i, bus.count, i);
            end
        end
        drive(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.count !== 8'd5) begin
                n_bad++;
                $display("FAIL hold_%0d: count=%0d expected=5",
                         i, bus.count);
            end
        end
    endtask

    task automatic test_toggle();
        logic [7:0] exp_seq [3];
        logic       en_seq  [3];
        exp_seq = '{8'd1, 8'd1, 8'd2};
        en_seq  = '{1'b1, 1'b0, 1'b1};
        drive(1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, en_seq[i]);
            tick();
            n_cmp++;
            if (bus.count !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL toggle_%0d: count=%0d expected=%0d",
                         i, bus.count, exp_seq[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int errs;
        errs = 0;
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b1);
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (bus.count !== 8'(i)) errs++;
        end
        n_cmp++;
        if (errs != 0 || bus.count !== 8'd255) begin
            n_bad++;
            $display("FAIL ramp: count=%0d expected=255 step_errs=%0d",
                     bus.count, errs);
        end
        tick();
        n_cmp++;
        if (bus.count !== 8'd0) begin
            n_bad++;
            $display("FAIL wrap: count=%0d expected=0", bus.count);
        end
        tick();
        n_cmp++;
        if (bus.count !== 8'd1) begin
            n_bad++;
            $display("FAIL after_wrap: count=%0d expected=1", bus.count);
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b1);
        repeat (37) tick();
        n_cmp++;
        if (bus.count !== 8'd37) begin
            n_bad++;
            $display("FAIL reach_37: count=%0d expected=37", bus.count);
        end
        drive(1'b1, 1'b1);
        #2;
        n_cmp++;
        if (bus.count !== 8'd37) begin
            n_bad++;
            $display("FAIL sync_reset: count=%0d expected=37", bus.count);
        end
        tick();
        n_cmp++;
        if (bus.count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_prio: count=%0d expected=0", bus.count);
        end
        drive(1'b0, 1'b1);
        tick();
        n_cmp++;
        if (bus.count !== 8'd1) begin
            n_bad++;
            $display("FAIL resume: count=%0d expected=1", bus.count);
        end
    endtask

    task automatic test_glitch();
        drive(1'b0, 1'b1);
        tick();
        n_cmp++;
        if (bus.count !== 8'd2) begin
            n_bad++;
            $display("FAIL pre_glitch: count=%0d expected=2", bus.count);
        end
        drive(1'b0, 1'b0);
        #1;
        bus.reset = 1'b1;
        bus.en    = 1'b1;
        #2;
        bus.reset = 1'b0;
        bus.en    = 1'b0;
        n_cmp++;
        if (bus.count !== 8'd2) begin
            n_bad++;
            $display("FAIL glitch_mid: count=%0d expected=2", bus.count);
        end
        tick();
        n_cmp++;
        if (bus.count !== 8'd2) begin
            n_bad++;
            $display("FAIL glitch_edge: count=%0d expected=2", bus.count);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        bus.reset = 1'b0;
        bus.en    = 1'b0;
        test_reset();
        test_count_hold();
        test_toggle();
        test_wrap();
        test_reset_priority();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
